xeng_corr_apply: RTL
====================

// Module: xeng_corr_apply
// PURPOSE
//  Consumer of the component-tracker correction stream. Buffers per-baseline re/im corrections
//  for xx/xy/yx/yy, aligns them with X-engine accumulator output, and subtracts the scaled
//  offset term so that the output visibilities are true signed results of the uint-offset
//  real-part products. Sits between the X-engine vacc output and the packetiser.
// PARAMETERS
//  BITWIDTH        4   bits per re/im sample part; OFFSET_SHIFT = BITWIDTH-1
//  SERIAL_ACC_LEN_BITS 7  serial accumulation length (2^n)
//  P_FACTOR_BITS   2   parallel samples (2^n); CW = P_FACTOR_BITS+SERIAL_ACC_LEN_BITS+BITWIDTH+3
//  XENG_WIDTH      32  width of one raw re or im accumulator word
//  FIFO_DEPTH_BITS 4   correction FIFO depth = 2^n entries
// PORTS
//  clk          in  1        clock
//  rst_n        in  1        async active-low reset
//  sync         in  1        sync pulse; flushes FIFO, clears counters/flags
//  corr_vld     in  1        correction entry valid (push)
//  corr_re      in  4*CW     {xx,xy,yx,yy} re corrections, signed
//  corr_im      in  4*CW     {xx,xy,yx,yy} im corrections, signed
//  corr_last    in  1        entry belongs to last baseline triangle
//  corr_buf_sel in  1        tracker buffer select for entry
//  xeng_vld     in  1        raw accumulator word valid (pop)
//  xeng_re      in  4*XW     raw re {xx,xy,yx,yy}, signed
//  xeng_im      in  4*XW     raw im {xx,xy,yx,yy}, signed
//  dout_vld     out 1        corrected word valid
//  dout_re      out 4*XW     corrected re, signed
//  dout_im      out 4*XW     corrected im, signed
//  dout_last    out 1        corr_last of applied entry
//  dout_buf_sel out 1        corr_buf_sel of applied entry
//  int_cnt      out 16       completed integrations
//  fifo_level   out FIFO_DEPTH_BITS+1  entries held
//  err_underflow out 1       sticky: pop with no correction available
//  err_overflow out 1        sticky: push dropped while full
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, FIFO empty, rd/wr pointers 0.
//  - sync=1 (sync-edge): same clearing as reset on next edge; corr_vld/xeng_vld in same cycle ignored.
//  - FIFO: 2^FIFO_DEPTH_BITS x (8*CW+2), pointers wrap mod depth, level = wr-rd in FIFO_DEPTH_BITS+1 bits.
//  - Push when corr_vld & (!full | pop this cycle); full & corr_vld & !xeng_vld -> drop, err_overflow=1.
//  - Pop when xeng_vld. Empty & corr_vld & xeng_vld -> bypass: incoming entry applied, level unchanged.
//  - Empty & xeng_vld & !corr_vld -> correction 0, last=0, buf_sel held, err_underflow=1, dout_vld still 1.
//  - Pipeline, 2 cycles: cycle0 register raw + selected correction; cycle1 compute & register output.
//    dout_vld = xeng_vld delayed 2; dout_last/dout_buf_sel delayed with data.
//  - Arithmetic per product p: dout_re[p] = xeng_re[p] - sext(corr_re[p]) <<< OFFSET_SHIFT;
//    dout_im[p] = xeng_im[p] - sext(corr_im[p]) <<< OFFSET_SHIFT; result wraps mod 2^XW (no saturation).
//  - int_cnt increments (wrap at 2^16) on cycle dout_vld & dout_last and the following dout_vld word has
//    dout_last=0, i.e. on the falling edge of last-triangle across valid words.
//  - dout_buf_sel toggle without preceding last-triangle end is not checked (packetiser concern).
//  - Error flags are sticky until reset or sync.
// TESTING
//  1 Push 1 entry corr_re.xx=3, then xeng_vld xeng_re.xx=100 (BITWIDTH=4) -> 2 cycles later dout_re.xx=76, dout_vld=1.
//  2 corr_im.yy=-5, xeng_im.yy=-10 -> dout_im.yy=30; corr_re.xy=1, xeng_re.xy=0 -> dout_re.xy=-8.
//  3 Push 17 entries with no pop (depth 16) -> fifo_level=16, err_overflow=1, 16 pops return first 16 in order.
//  4 xeng_vld with FIFO empty, no corr_vld -> dout = raw unchanged, err_underflow=1; with corr_vld same cycle -> bypass applied, no error.
//  5 Entries last=1,1,0 applied in order -> int_cnt 0->1 after third word; sync then -> int_cnt=0, fifo_level=0, flags 0.
//  6 Deassert rst_n mid-pipeline with dout_vld pending -> dout_vld=0 immediately, no output after release.

Source files
------------

// File: rtl/xeng_corr_apply.sv
// ---------------------------------------------------------------------------
// xeng_corr_apply
//   Applies component-tracker offset corrections to X-engine accumulator
//   words. Each correction entry carries signed re/im terms for the four
//   polarisation products {xx,xy,yx,yy}. The entries are buffered in a small
//   FIFO and consumed one per raw accumulator word. The scaled term
//   (corr <<< OFFSET_SHIFT) is subtracted so that the uint-offset products
//   become true signed visibilities. Results wrap modulo 2^XENG_WIDTH.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   sync               synchronous clear of the FIFO, pipeline, counters and
//                      flags; valid inputs in the same cycle are ignored
//   corr_vld           push a correction entry
//   corr_re, corr_im   {xx,xy,yx,yy} signed corrections, CW bits each
//   corr_last          the entry belongs to the last baseline triangle
//   corr_buf_sel       tracker buffer select for the entry
//   xeng_vld           raw accumulator word valid; pops one correction
//   xeng_re, xeng_im   {xx,xy,yx,yy} signed raw words, XENG_WIDTH bits each
//   dout_vld           corrected word valid, two cycles after xeng_vld
//   dout_re, dout_im   corrected {xx,xy,yx,yy}
//   dout_last          corr_last of the applied entry
//   dout_buf_sel       corr_buf_sel of the applied entry
//   int_cnt            completed integrations (end of last triangle seen)
//   fifo_level         number of entries held
//   err_underflow      sticky: word arrived with no correction available
//   err_overflow       sticky: a push was dropped while full
// ---------------------------------------------------------------------------
module xeng_corr_apply #(
    parameter  int BITWIDTH            = 4,
    parameter  int SERIAL_ACC_LEN_BITS = 7,
    parameter  int P_FACTOR_BITS       = 2,
    parameter  int XENG_WIDTH          = 32,
    parameter  int FIFO_DEPTH_BITS     = 4,
    localparam int CW = P_FACTOR_BITS + SERIAL_ACC_LEN_BITS + BITWIDTH + 3,
    localparam int XW = XENG_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sync,
    input  logic                       corr_vld,
    input  logic [4*CW-1:0]            corr_re,
    input  logic [4*CW-1:0]            corr_im,
    input  logic                       corr_last,
    input  logic                       corr_buf_sel,
    input  logic                       xeng_vld,
    input  logic [4*XW-1:0]            xeng_re,
    input  logic [4*XW-1:0]            xeng_im,
    output logic                       dout_vld,
    output logic [4*XW-1:0]            dout_re,
    output logic [4*XW-1:0]            dout_im,
    output logic                       dout_last,
    output logic                       dout_buf_sel,
    output logic [15:0]                int_cnt,
    output logic [FIFO_DEPTH_BITS:0]   fifo_level,
    output logic                       err_underflow,
    output logic                       err_overflow
);

    localparam int DEPTH        = 1 << FIFO_DEPTH_BITS;
    localparam int OFFSET_SHIFT = BITWIDTH - 1;
    localparam int EW           = 8 * CW + 2;

    // FIFO storage and bookkeeping; entry = {last, buf_sel, re, im}
    logic [EW-1:0]              mem_q [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_BITS:0]   count_q, count_d;

    // Stage 0 registers: raw word plus the correction chosen for it
    logic                       s1_vld_q;
    logic [4*XW-1:0]            s1_re_q, s1_im_q;
    logic [4*CW-1:0]            s1_cre_q, s1_cim_q;
    logic                       s1_last_q, s1_bsel_q;

    // Output stage registers
    logic                       dout_vld_q, dout_last_q, dout_bsel_q;
    logic [4*XW-1:0]            dout_re_q, dout_im_q;
    logic [15:0]                int_cnt_q;
    logic                       seen_last_q;
    logic                       err_under_q, err_over_q;

    logic                       live_corr, live_xeng;
    logic                       empty, full;
    logic                       fifo_pop, bypass, push, drop, under;
    logic [EW-1:0]              in_entry, head;
    logic                       sel_last, sel_bsel;
    logic [4*CW-1:0]            sel_re, sel_im;
    logic [4*XW-1:0]            res_re_d, res_im_d;
    logic [XW-1:0]              cre_ext, cim_ext;

    always_comb begin
        live_corr = corr_vld & ~sync;
        live_xeng = xeng_vld & ~sync;
        empty     = (count_q == '0);
        full      = (count_q == (FIFO_DEPTH_BITS+1)'(DEPTH));
        fifo_pop  = live_xeng & ~empty;
        // Empty FIFO with an entry arriving alongside the word: apply it
        // directly instead of storing it.
        bypass    = live_xeng & empty & live_corr;
        push      = live_corr & ~bypass & (~full | fifo_pop);
        drop      = live_corr & full & ~live_xeng;
        under     = live_xeng & empty & ~live_corr;
        in_entry  = {corr_last, corr_buf_sel, corr_re, corr_im};
        head      = mem_q[rd_ptr_q];

        sel_last = 1'b0;
        sel_bsel = s1_bsel_q;
        sel_re   = '0;
        sel_im   = '0;
        if (fifo_pop) begin
            {sel_last, sel_bsel, sel_re, sel_im} = head;
        end else if (bypass) begin
            {sel_last, sel_bsel, sel_re, sel_im} = in_entry;
        end

        count_d = count_q;
        if (push && !fifo_pop) begin
            count_d = count_q + 1'b1;
        end else if (fifo_pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Subtract the sign-extended, scaled correction per product lane
    always_comb begin
        res_re_d = '0;
        res_im_d = '0;
        cre_ext  = '0;
        cim_ext  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cre_ext = {{(XW-CW){s1_cre_q[k*CW + CW - 1]}}, s1_cre_q[k*CW +: CW]};
            cim_ext = {{(XW-CW){s1_cim_q[k*CW + CW - 1]}}, s1_cim_q[k*CW +: CW]};
            res_re_d[k*XW +: XW] = s1_re_q[k*XW +: XW] - (cre_ext << OFFSET_SHIFT);
            res_im_d[k*XW +: XW] = s1_im_q[k*XW +: XW] - (cim_ext << OFFSET_SHIFT);
        end
    end

    // Storage array needs no reset: validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s1_vld_q    <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_cre_q    <= '0;
            s1_cim_q    <= '0;
            s1_last_q   <= 1'b0;
            s1_bsel_q   <= 1'b0;
            dout_vld_q  <= 1'b0;
            dout_re_q   <= '0;
            dout_im_q   <= '0;
            dout_last_q <= 1'b0;
            dout_bsel_q <= 1'b0;
            int_cnt_q   <= '0;
            seen_last_q <= 1'b0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else if (sync) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s1_vld_q    <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_cre_q    <= '0;
            s1_cim_q    <= '0;
            s1_last_q   <= 1'b0;
            s1_bsel_q   <= 1'b0;
            dout_vld_q  <= 1'b0;
            dout_re_q   <= '0;
            dout_im_q   <= '0;
            dout_last_q <= 1'b0;
            dout_bsel_q <= 1'b0;
            int_cnt_q   <= '0;
            seen_last_q <= 1'b0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (drop) begin
                err_over_q <= 1'b1;
            end
            if (under) begin
                err_under_q <= 1'b1;
            end

            s1_vld_q <= live_xeng;
            if (live_xeng) begin
                s1_re_q   <= xeng_re;
                s1_im_q   <= xeng_im;
                s1_cre_q  <= sel_re;
                s1_cim_q  <= sel_im;
                s1_last_q <= sel_last;
                s1_bsel_q <= sel_bsel;
            end

            dout_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                dout_re_q   <= res_re_d;
                dout_im_q   <= res_im_d;
                dout_last_q <= s1_last_q;
                dout_bsel_q <= s1_bsel_q;
                // Integration ends when a last-triangle word is followed by
                // a non-last word; count it as that word is emitted.
                if (seen_last_q && !s1_last_q) begin
                    int_cnt_q <= int_cnt_q + 16'd1;
                end
                seen_last_q <= s1_last_q;
            end
        end
    end

    assign dout_vld      = dout_vld_q;
    assign dout_re       = dout_re_q;
    assign dout_im       = dout_im_q;
    assign dout_last     = dout_last_q;
    assign dout_buf_sel  = dout_bsel_q;
    assign int_cnt       = int_cnt_q;
    assign fifo_level    = count_q;
    assign err_underflow = err_under_q;
    assign err_overflow  = err_over_q;

endmodule
